uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side sequencer for the UART RX path. Detects a falling edge on the serial line, then tracks oversampling edges and bit positions through start, data, optional parity and stop bits. Emits one-cycle enables to the start/parity/stop checkers and the deserializer, and enables the data sampler. Collects checker error flags into a single `data_valid` pulse per good frame.

## Interface
- `DATA_WIDTH`, 8, data bits per frame
- `PRESCALE_W`, 6, width of `Prescale` and `edge_cnt`
- `CLK`  in  1  system clock
- `RST`  in  1  asynchronous, active-high reset
- `RX_IN`  in  1  serial line, idle high
- `PAR_EN`  in  1  frame carries a parity bit
- `Prescale`  in  PRESCALE_W  oversampling ratio; legal values 8, 16, 32
- `strt_glitch`  in  1  start-checker error, registered
- `par_err`  in  1  parity-checker error, registered
- `stp_err`  in  1  stop-checker error, registered
- `dat_samp_en`  out  1  data sampler enable
- `edge_cnt`  out  PRESCALE_W  oversampling edge index within current bit
- `bit_cnt`  out  4  bit index within frame; start bit = 0
- `strt_chk_en` / `par_chk_en` / `stp_chk_en`  out  1  one-cycle checker strobes
- `deser_en`  out  1  one-cycle deserializer shift strobe
- `data_valid`  out  1  one-cycle good-frame pulse, registered

## Operation
- States: IDLE, START, DATA, PARITY, STOP, ERR_CHK.
- IDLE: `edge_cnt = 0`, `bit_cnt = 0`. If `RX_IN == 0`, go to START.
- On IDLE→START, latch `PAR_EN` and `Prescale` into frame registers. Input changes mid-frame have no effect.
- Edge counter, all states except IDLE and ERR_CHK:
  - increments every cycle;
  - at `P-1` (P = latched Prescale), wraps to 0 and increments `bit_cnt`.
- Strobe point S = P/2+2: the sampler's majority result is registered and stable here.
- START:
  - `strt_chk_en` high when `edge_cnt == S`.
  - At `edge_cnt == P-1`: if `strt_glitch`, go to IDLE; else go to DATA.
- DATA:
  - `deser_en` high when `edge_cnt == S`.
  - At wrap with `bit_cnt == DATA_WIDTH`: go to PARITY if latched PAR_EN, else STOP.
- PARITY: `par_chk_en` high when `edge_cnt == S`. At wrap, go to STOP.
- STOP:
  - `stp_chk_en` high when `edge_cnt == S`.
  - At `edge_cnt == S+1` (checker result visible), go to ERR_CHK.
- ERR_CHK (one cycle):
  - `data_valid` registers `!stp_err && !(latched PAR_EN && par_err)`.
  - Clear both counters.
  - Next state is START if `RX_IN == 0` (back-to-back frame, latches refreshed), else IDLE.
- `dat_samp_en = 1` in START, DATA, PARITY and STOP; 0 otherwise.
- All strobes and `dat_samp_en` decode from state and counters. `data_valid` is a flop.

## Timing
- Reset (asynchronous): state IDLE, counters 0, `data_valid` 0. All strobes 0 from the same instant, including mid-frame.
- Frame latency: falling edge of `RX_IN` seen in IDLE → `data_valid` high exactly one cycle.
- No-parity frame at Prescale 8: `data_valid` high (DATA_WIDTH+1)·8 + 8 cycles after the IDLE→START cycle. With parity, add 8.
- Each strobe is high for exactly one cycle per bit. `deser_en` fires exactly DATA_WIDTH times per frame.
- Glitched start: return to IDLE at `edge_cnt == P-1` of the start bit. No `deser_en`, no `data_valid`.
- Stop early exit: leaves P-S-2 cycles of margin before the next start bit, which allows back-to-back frames.
- `par_err` is ignored when latched PAR_EN is 0.
- Out-of-range `Prescale` is unsupported. Behaviour is unspecified but must not lock up; reset recovers.

## Structure
- Package `uart_rx_pkg`:
  - state enum, binary-encoded, 3 bits;
  - `DATA_WIDTH` default;
  - strobe-offset constant (+2) and ERR_CHK offset (+1).
- Natural sub-module: `uart_rx_edge_bit_cnt`, holding the edge and bit counters with wrap and clear. It takes `cnt_en`, `clr` and latched Prescale; the FSM drives `cnt_en` and `clr`.

## Test plan
- Prescale 8, PAR_EN 0, byte 0xA5, good stop → 8 `deser_en` pulses at `edge_cnt` 6; one `data_valid` pulse 80 cycles after the start edge.
- Prescale 16, PAR_EN 1, byte 0x3C, even parity correct → `par_chk_en` once at `edge_cnt` 10; `data_valid` pulse.
- 3-cycle low glitch on `RX_IN`, Prescale 8, `strt_glitch` returns 1 → back to IDLE at `edge_cnt` 7; no `deser_en`; `data_valid` stays 0.
- Stop bit sampled 0 (`stp_err` = 1) → ERR_CHK reached; `data_valid` stays 0; next frame is received normally.
- Two back-to-back frames, 0x55 then 0xAA, no idle gap, with PAR_EN toggled mid-frame → two `data_valid` pulses. Parity handling follows the PAR_EN value latched at each frame's start.
- `RST` pulsed while `bit_cnt == 4` in DATA → all outputs 0 immediately; following frame 0xFF is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive sequencer.
// The state encoding and sampling offsets live here so every RX block agrees on them.
package uart_rx_pkg;

   localparam int DATA_WIDTH_DEF = 8;

   // The sampler's majority vote is registered two edges past mid-bit; the
   // stop checker's verdict becomes visible one edge after its strobe.
   localparam int STROBE_OFS  = 2;
   localparam int ERR_CHK_OFS = 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      START   = 3'd1,
      DATA    = 3'd2,
      PARITY  = 3'd3,
      STOP    = 3'd4,
      ERR_CHK = 3'd5
   } rxState_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the RX sequencer and its serial line, checkers and datapath.
// The slave side is the sequencer; the master side is whatever surrounds it.
interface uart_rx_ctrl_if #(
   parameter int PRESCALE_W = 6
);
   logic                  RX_IN;
   logic                  PAR_EN;
   logic [PRESCALE_W-1:0] Prescale;
   logic                  strt_glitch;
   logic                  par_err;
   logic                  stp_err;
   logic                  dat_samp_en;
   logic [PRESCALE_W-1:0] edge_cnt;
   logic [3:0]            bit_cnt;
   logic                  strt_chk_en;
   logic                  par_chk_en;
   logic                  stp_chk_en;
   logic                  deser_en;
   logic                  data_valid;

   modport master (
      output RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
      input  dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, par_chk_en,
             stp_chk_en, deser_en, data_valid
   );

   modport slave (
      input  RX_IN, PAR_EN, Prescale, strt_glitch, par_err, stp_err,
      output dat_samp_en, edge_cnt, bit_cnt, strt_chk_en, par_chk_en,
             stp_chk_en, deser_en, data_valid
   );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversampling edge counter and frame bit counter for the RX sequencer.
// The edge count wraps at prescale-1 and carries into the bit count; clr has priority.
module uart_rx_edge_bit_cnt
   import uart_rx_pkg::*;
#(
   parameter int PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cnt_en,
   input  logic                  clr,
   input  logic [PRESCALE_W-1:0] prescale_i,
   output logic [PRESCALE_W-1:0] edge_cnt_o,
   output logic [3:0]            bit_cnt_o,
   output logic                  last_edge_o
);

   logic [PRESCALE_W-1:0] edgeCnt_q, edgeCnt_d;
   logic [3:0]            bitCnt_q, bitCnt_d;
   logic                  atLastEdge;

   // A prescale of zero makes the compare value all ones, so the counter still wraps.
   assign atLastEdge  = (edgeCnt_q == prescale_i - PRESCALE_W'(1));
   assign last_edge_o = atLastEdge;
   assign edge_cnt_o  = edgeCnt_q;
   assign bit_cnt_o   = bitCnt_q;

   always_comb begin
      edgeCnt_d = edgeCnt_q;
      bitCnt_d  = bitCnt_q;
      if (clr) begin
         edgeCnt_d = '0;
         bitCnt_d  = '0;
      end else if (cnt_en) begin
         if (atLastEdge) begin
            edgeCnt_d = '0;
            bitCnt_d  = bitCnt_q + 4'd1;
         end else begin
            edgeCnt_d = edgeCnt_q + PRESCALE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         edgeCnt_q <= '0;
         bitCnt_q  <= '0;
      end else begin
         edgeCnt_q <= edgeCnt_d;
         bitCnt_q  <= bitCnt_d;
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: walks start, data, optional parity and stop bits,
// strobes the checkers and deserializer, and flags each good frame with data_valid.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PRESCALE_W = 6
) (
   input logic           CLK,
   input logic           RST,
   uart_rx_ctrl_if.slave bus
);

   rxState_e              state_q, state_d;
   logic                  parEn_q, parEn_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic                  dataValid_q, dataValid_d;

   logic [PRESCALE_W-1:0] edgeCnt;
   logic [PRESCALE_W-1:0] strobePt;
   logic [PRESCALE_W-1:0] errChkPt;
   logic [3:0]            bitCnt;
   logic                  lastEdge;
   logic                  cntEn;
   logic                  cntClr;
   logic                  atStrobe;
   logic                  stopExit;

   assign strobePt = (prescale_q >> 1) + PRESCALE_W'(STROBE_OFS);
   assign errChkPt = strobePt + PRESCALE_W'(ERR_CHK_OFS);
   assign atStrobe = (edgeCnt == strobePt);
   // The wrap term only matters for out-of-range prescales where S+1 is never reached.
   assign stopExit = (edgeCnt == errChkPt) || lastEdge;

   uart_rx_edge_bit_cnt #(
      .PRESCALE_W (PRESCALE_W)
   ) u_cnt (
      .clk         (CLK),
      .rst         (RST),
      .cnt_en      (cntEn),
      .clr         (cntClr),
      .prescale_i  (prescale_q),
      .edge_cnt_o  (edgeCnt),
      .bit_cnt_o   (bitCnt),
      .last_edge_o (lastEdge)
   );

   assign bus.edge_cnt   = edgeCnt;
   assign bus.bit_cnt    = bitCnt;
   assign bus.data_valid = dataValid_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= IDLE;
         parEn_q     <= 1'b0;
         prescale_q  <= '0;
         dataValid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         parEn_q     <= parEn_d;
         prescale_q  <= prescale_d;
         dataValid_q <= dataValid_d;
      end
   end

   // Frame settings are captured only when a start bit is accepted, so they
   // stay fixed for the whole frame. The verdict is captured on the way into
   // ERR_CHK, which makes the data_valid pulse coincide with that state.
   always_comb begin
      state_d     = state_q;
      parEn_d     = parEn_q;
      prescale_d  = prescale_q;
      dataValid_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (!bus.RX_IN) begin
               state_d    = START;
               parEn_d    = bus.PAR_EN;
               prescale_d = bus.Prescale;
            end
         end
         START: begin
            if (lastEdge) state_d = bus.strt_glitch ? IDLE : DATA;
         end
         DATA: begin
            if (lastEdge && (bitCnt == 4'(DATA_WIDTH))) state_d = parEn_q ? PARITY : STOP;
         end
         PARITY: begin
            if (lastEdge) state_d = STOP;
         end
         STOP: begin
            if (stopExit) begin
               state_d     = ERR_CHK;
               dataValid_d = !bus.stp_err && !(parEn_q && bus.par_err);
            end
         end
         ERR_CHK: begin
            if (!bus.RX_IN) begin
               state_d    = START;
               parEn_d    = bus.PAR_EN;
               prescale_d = bus.Prescale;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes decode purely from state and counters so reset silences them at once.
   always_comb begin
      cntEn           = 1'b0;
      cntClr          = 1'b0;
      bus.dat_samp_en = 1'b0;
      bus.strt_chk_en = 1'b0;
      bus.deser_en    = 1'b0;
      bus.par_chk_en  = 1'b0;
      bus.stp_chk_en  = 1'b0;
      case (state_q)
         START: begin
            cntEn           = 1'b1;
            cntClr          = lastEdge && bus.strt_glitch;
            bus.dat_samp_en = 1'b1;
            bus.strt_chk_en = atStrobe;
         end
         DATA: begin
            cntEn           = 1'b1;
            bus.dat_samp_en = 1'b1;
            bus.deser_en    = atStrobe;
         end
         PARITY: begin
            cntEn           = 1'b1;
            bus.dat_samp_en = 1'b1;
            bus.par_chk_en  = atStrobe;
         end
         STOP: begin
            cntEn           = 1'b1;
            bus.dat_samp_en = 1'b1;
            bus.stp_chk_en  = atStrobe;
         end
         default: cntClr = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frames plus randomized frames,
// scored against an event timeline derived from frame length and sampling points.
module tb_uart_rx_ctrl;

   localparam int DW = 8;
   localparam int PW = 6;

   localparam int K_NONE  = 0;
   localparam int K_STRT  = 1;
   localparam int K_DESER = 2;
   localparam int K_PAR   = 3;
   localparam int K_STOP  = 4;
   localparam int K_DV    = 5;
   localparam int K_MULTI = 9;

   typedef struct {
      int cyc;
      int kind;
      int edgeCnt;
      int bitCnt;
   } expEvent_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   cycle = 0;
   int   compared = 0;
   int   mismatched = 0;
   int   ready = 0;

   expEvent_t evQ[$];
   int        winStart[$];
   int        winEnd[$];

   uart_rx_ctrl_if #(.PRESCALE_W(PW)) bus ();

   uart_rx_ctrl #(
      .DATA_WIDTH (DW),
      .PRESCALE_W (PW)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input int actual, input int expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cycle);
      end
   endtask

   task automatic pushEvent(input int cyc, input int kind, input int edgeCnt, input int bitCnt);
      expEvent_t ev;
      ev.cyc     = cyc;
      ev.kind    = kind;
      ev.edgeCnt = edgeCnt;
      ev.bitCnt  = bitCnt;
      evQ.push_back(ev);
   endtask

   // Compares every cycle's strobes and sampler enable against the expected timeline.
   always @(negedge CLK) begin
      int obs;
      int nHigh;
      int expDsen;
      if (!RST) begin
         obs   = K_NONE;
         nHigh = 0;
         if (bus.strt_chk_en) begin obs = K_STRT;  nHigh++; end
         if (bus.deser_en)    begin obs = K_DESER; nHigh++; end
         if (bus.par_chk_en)  begin obs = K_PAR;   nHigh++; end
         if (bus.stp_chk_en)  begin obs = K_STOP;  nHigh++; end
         if (bus.data_valid)  begin obs = K_DV;    nHigh++; end
         if (nHigh > 1) obs = K_MULTI;
         if (evQ.size() > 0 && evQ[0].cyc == cycle) begin
            checkOutput("event kind", obs, evQ[0].kind);
            if (evQ[0].kind != K_DV) begin
               checkOutput("strobe edge_cnt", int'(bus.edge_cnt), evQ[0].edgeCnt);
               checkOutput("strobe bit_cnt", int'(bus.bit_cnt), evQ[0].bitCnt);
            end
            void'(evQ.pop_front());
         end else if (obs != K_NONE) begin
            checkOutput("unexpected strobe", obs, K_NONE);
         end
         while (winEnd.size() > 0 && cycle > winEnd[0]) begin
            void'(winStart.pop_front());
            void'(winEnd.pop_front());
         end
         expDsen = (winStart.size() > 0 && cycle >= winStart[0]) ? 1 : 0;
         checkOutput("dat_samp_en", int'(bus.dat_samp_en), expDsen);
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, " data_valid"}, int'(bus.data_valid), 0);
      checkOutput({tag, " strobes"}, int'(bus.strt_chk_en) + int'(bus.deser_en) +
                  int'(bus.par_chk_en) + int'(bus.stp_chk_en), 0);
      checkOutput({tag, " dat_samp_en"}, int'(bus.dat_samp_en), 0);
      checkOutput({tag, " edge_cnt"}, int'(bus.edge_cnt), 0);
      checkOutput({tag, " bit_cnt"}, int'(bus.bit_cnt), 0);
   endtask

   task automatic idleGap(input int n);
      bus.RX_IN = 1'b1;
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
      if (n >= 3) begin
         checkOutput("idle edge_cnt", int'(bus.edge_cnt), 0);
         checkOutput("idle bit_cnt", int'(bus.bit_cnt), 0);
      end
   endtask

   // Drives one complete frame on the line and records the timeline it should produce.
   task automatic sendFrame(input logic [7:0] data, input int p, input bit parEn,
                            input bit parErr, input bit stpErr, input bit toggle,
                            input int resetAt);
      int c, tStart, s, nb, frameLen, b;
      logic lineBit;
      c      = cycle;
      tStart = ((ready > c) ? ready : c) + 1;
      s      = p / 2 + 2;
      nb     = 1 + DW + (parEn ? 1 : 0);
      pushEvent(tStart + s, K_STRT, s, 0);
      for (int k = 1; k <= DW; k++) pushEvent(tStart + k * p + s, K_DESER, s, k);
      if (parEn) pushEvent(tStart + (DW + 1) * p + s, K_PAR, s, DW + 1);
      pushEvent(tStart + nb * p + s, K_STOP, s, nb);
      if (!stpErr && !(parEn && parErr)) pushEvent(tStart + nb * p + s + 2, K_DV, 0, 0);
      winStart.push_back(tStart);
      winEnd.push_back(tStart + nb * p + s + 1);
      ready = tStart + nb * p + s + 2;

      bus.PAR_EN   = parEn;
      bus.Prescale = PW'(p);
      frameLen     = (nb + 1) * p;
      for (int i = 0; i < frameLen; i++) begin
         b = i / p;
         if (b == 0)                       lineBit = 1'b0;
         else if (b <= DW)                 lineBit = data[b-1];
         else if (parEn && b == DW + 1)    lineBit = (^data) ^ parErr;
         else                              lineBit = 1'b1;
         bus.RX_IN = lineBit;
         if (i == p / 2) begin
            bus.strt_glitch = 1'b0;
            bus.par_err     = parErr;
            bus.stp_err     = stpErr;
            if (toggle) begin
               bus.PAR_EN   = !parEn;
               bus.Prescale = PW'((p == 8) ? 16 : 8);
            end
         end
         if (i == resetAt) begin
            checkOutput("bit_cnt before reset", int'(bus.bit_cnt), (cycle - tStart) / p);
            #2;
            RST = 1'b1;
            evQ.delete();
            winStart.delete();
            winEnd.delete();
            #1;
            checkAllZero("async reset");
            bus.RX_IN   = 1'b1;
            bus.par_err = 1'b0;
            bus.stp_err = 1'b0;
            @(posedge CLK);
            #1;
            RST   = 1'b0;
            ready = 0;
            return;
         end
         @(posedge CLK);
         #1;
      end
   endtask

   // Short low pulse that the start checker rejects; only the start strobe may fire.
   task automatic sendGlitch(input int p, input int lowLen);
      int c, tStart, s;
      c      = cycle;
      tStart = ((ready > c) ? ready : c) + 1;
      s      = p / 2 + 2;
      pushEvent(tStart + s, K_STRT, s, 0);
      winStart.push_back(tStart);
      winEnd.push_back(tStart + p - 1);
      ready = tStart + p;
      bus.PAR_EN   = 1'($urandom_range(0, 1));
      bus.Prescale = PW'(p);
      for (int i = 0; i < p + 2; i++) begin
         bus.RX_IN = (i < lowLen) ? 1'b0 : 1'b1;
         if (i == p / 2) bus.strt_glitch = 1'b1;
         if (cycle == tStart + p - 1) checkOutput("glitch exit edge_cnt", int'(bus.edge_cnt), p - 1);
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      bit lastB2b;
      bus.RX_IN       = 1'b1;
      bus.PAR_EN      = 1'b0;
      bus.Prescale    = PW'(8);
      bus.strt_glitch = 1'b0;
      bus.par_err     = 1'b0;
      bus.stp_err     = 1'b0;
      repeat (3) @(posedge CLK);
      #1;
      checkAllZero("reset state");
      RST = 1'b0;
      idleGap(4);

      sendFrame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      idleGap(5);
      sendFrame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      idleGap(5);
      sendGlitch(8, 3);
      idleGap(5);
      sendFrame(8'h96, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1);
      idleGap(5);
      sendFrame(8'h81, 8, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      idleGap(5);
      sendFrame(8'h55, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      sendFrame(8'hAA, 8, 1'b0, 1'b1, 1'b0, 1'b1, -1);
      idleGap(5);
      sendFrame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 36);
      idleGap(5);
      sendFrame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      idleGap(5);

      lastB2b = 1'b0;
      for (int n = 0; n < 24; n++) begin
         int p;
         p = 8 << $urandom_range(0, 2);
         sendFrame(8'($urandom), p, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)), -1);
         if (!lastB2b && $urandom_range(0, 3) == 0) begin
            lastB2b = 1'b1;
         end else begin
            lastB2b = 1'b0;
            idleGap($urandom_range(3, 20));
         end
      end

      idleGap(20);
      checkOutput("leftover expected events", evQ.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
